// File: rtl/vid_fetch_if.sv
// Memory-arbiter read port used by the video prefetcher.
// Requests are in order; read data returns in request order.
interface vid_fetch_if;
   logic        mem_req;
   logic [17:0] mem_adr;
   logic        mem_ack;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_adr,
      input  mem_ack, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_adr,
      output mem_ack, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/vid_fetch.sv
// Video line prefetcher: walks a bottom-up framebuffer line by line
// into a word FIFO that the display controller drains on vid_req edges.
module vid_fetch #(
   parameter logic [17:0] BASE  = 18'h3D7E0,
   parameter int          LINES = 768,
   parameter int          DEPTH = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vsync,
   input  logic        vid_req,
   output logic [31:0] viddata,
   output logic        underrun,
   vid_fetch_if.master mem
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int LW = (LINES > 1) ? $clog2(LINES) : 1;

   typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

   state_t        state, state_n;
   logic          vs_q, vr_q, pop_q;
   logic [31:0]   ram [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [CW-1:0] fifo_count, count_n;
   logic [2:0]    in_flight, in_flight_n;
   logic          stale, stale_n;
   logic [17:0]   line_start;
   logic [4:0]    word;
   logic [LW-1:0] line;

   logic frame_start, acc, ret, push, pop, take;
   logic last, space, req_n;

   always_comb begin
      frame_start = vsync & ~vs_q;
      acc         = mem.mem_req & mem.mem_ack;
      ret         = mem.mem_rvalid & (in_flight != 3'd0);
      push        = ret & ~stale & (state != IDLE) & ~frame_start;
      pop         = pop_q & ~frame_start;
      take        = pop & (fifo_count != '0);
      last        = (word == 5'd31) && (line == LW'(LINES - 1));
      in_flight_n = in_flight + {2'b0, acc} - {2'b0, ret};
      // reads issued before a flush must drain before refetching
      stale_n     = (frame_start | stale) & (in_flight_n != 3'd0);
      count_n     = frame_start ? '0
                  : fifo_count + CW'(push) - CW'(take);
      state_n     = state;
      if (frame_start)
         state_n = FETCH;
      else if (state == FETCH && acc && last)
         state_n = DONE;
      space = ({1'b0, count_n} + (CW+1)'(in_flight_n))
            < (CW+1)'(DEPTH);
      req_n = (state_n == FETCH) & ~stale_n
            & space & ~in_flight_n[2];
   end

   always_ff @(posedge clk)
      if (push)
         ram[wp] <= mem.mem_rdata;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         vs_q       <= 1'b0;
         vr_q       <= 1'b0;
         pop_q      <= 1'b0;
         wp         <= '0;
         rp         <= '0;
         fifo_count <= '0;
         in_flight  <= 3'd0;
         stale      <= 1'b0;
         line_start <= BASE;
         word       <= 5'd0;
         line       <= '0;
         viddata    <= 32'h0;
         underrun   <= 1'b0;
         mem.mem_req <= 1'b0;
         mem.mem_adr <= BASE;
      end else begin
         vs_q        <= vsync;
         vr_q        <= vid_req;
         pop_q       <= vid_req & ~vr_q;
         state       <= state_n;
         in_flight   <= in_flight_n;
         stale       <= stale_n;
         fifo_count  <= count_n;
         mem.mem_req <= req_n;
         if (frame_start) begin
            wp          <= '0;
            rp          <= '0;
            underrun    <= 1'b0;
            word        <= 5'd0;
            line        <= '0;
            line_start  <= BASE;
            mem.mem_adr <= BASE;
         end else begin
            if (push)
               wp <= wp + 1'b1;
            if (take)
               rp <= rp + 1'b1;
            if (pop) begin
               viddata <= take ? ram[rp] : 32'h0;
               if (!take)
                  underrun <= 1'b1;
            end
            // lines descend in memory; words ascend within a line
            if (acc && !last) begin
               if (word == 5'd31) begin
                  line_start  <= line_start - 18'd32;
                  mem.mem_adr <= line_start - 18'd32;
                  word        <= 5'd0;
                  line        <= line + 1'b1;
               end else begin
                  word        <= word + 5'd1;
                  mem.mem_adr <= mem.mem_adr + 18'd1;
               end
            end
         end
      end
   end

endmodule

// File: doc/vid_fetch.md
VID_FETCH -- requirements
Module: vid_fetch

Interface
REQ-001 Parameter BASE, default 18'h3D7E0, is the word address of the first (top) display line's word 0.
REQ-002 Parameter LINES, default 768, is the number of display lines fetched per frame.
REQ-003 Parameter DEPTH, default 64, is the prefetch FIFO depth in 32-bit words (power of two, >= 8).
REQ-004 clk  input  1  single system clock; all logic is on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-low.
REQ-006 vsync  input  1  frame marker from the display controller; active high.
REQ-007 vid_req  input  1  word request from the display controller (level; may stay high several cycles).
REQ-008 viddata  output  32  registered video word to the display controller.
REQ-009 mem_req  output  1  read request to the memory arbiter.
REQ-010 mem_adr  output  18  word address of the read; stable while mem_req is high.
REQ-011 mem_ack  input  1  arbiter accepted the read in this cycle.
REQ-012 mem_rvalid  input  1  read data valid this cycle; returns in request order.
REQ-013 mem_rdata  input  32  read data.
REQ-014 underrun  output  1  sticky flag: a pop was attempted while the FIFO was empty.

Function
REQ-015 Address generation: the fetch order is line by line, with words 0..31 in ascending address order within a line.
REQ-016 After the 32nd word of a line is issued, the next line starts at (line start - 32), i.e. addresses descend by line; all arithmetic is modulo 2^18.
REQ-017 The fetch state machine has three states:
- IDLE: no requests.
- FETCH: issue reads.
- DONE: all LINES*32 words issued; wait for the next frame.
REQ-018 Transitions:
- IDLE->FETCH on frame start.
- FETCH->DONE when the last word of line LINES-1 is accepted.
- DONE->FETCH on frame start.
- Any state->FETCH on frame start.
REQ-019 Frame start is the rising edge of vsync, detected from a registered copy of vsync. On frame start, in a single cycle:
- FIFO is flushed.
- Line and word counters reset.
- mem_adr is reloaded with BASE.
- underrun is cleared.
REQ-020 In-flight reads are counted (0..4); data returning after a flush is discarded until the in-flight count drains to 0.
REQ-021 mem_req is high in FETCH only when fifo_count + in_flight < DEPTH and in_flight < 4.
REQ-022 A read is accepted only in a cycle where mem_req && mem_ack. The address/word counter then advances in the next cycle, and in_flight increments, unless a return occurs in the same cycle (then in_flight is unchanged).
REQ-023 mem_req may deassert without mem_ack when the space condition fails. mem_adr shall not change while mem_req is high and not acked.
REQ-024 Push: mem_rvalid writes mem_rdata into the FIFO and decrements in_flight. FIFO overflow is impossible by REQ-021; a push into a full FIFO is a design error.
REQ-025 Pop: on each 0->1 transition of vid_req (registered edge detect), one word is popped, and viddata takes that word on the following clock edge.
REQ-026 Between pops, viddata holds its value.
REQ-027 Pop with the FIFO empty:
- viddata becomes 32'h0.
- underrun is set and stays set until frame start or reset.
- The FIFO pointers do not move.
REQ-028 Simultaneous push and pop in one cycle: both take effect, fifo_count is unchanged, and data order is preserved. When the FIFO is empty, a push and a pop in the same cycle is treated as an underrun; the pushed word is kept.
REQ-029 A frame start in the same cycle as a push or pop takes priority: flush wins, and the pushed or popped word is dropped.
REQ-030 Latency: from the first mem_rvalid of a frame to FIFO non-empty is 1 cycle; from the vid_req rising edge to viddata valid is 2 cycles (edge register + output register).

Reset
REQ-031 While rst is low:
- State is IDLE.
- mem_req = 0 and mem_adr = BASE.
- viddata = 0 and underrun = 0.
- FIFO is empty and in_flight = 0.
- The vsync and vid_req edge registers are 0.
REQ-032 Reset asserted mid-burst abandons outstanding reads. After release, the block ignores mem_rvalid until the first frame start, and stays in IDLE until that frame start.

Verification
REQ-033 Reset release, then vsync pulse, arbiter always acking, 1-cycle read latency -> mem_adr sequence 3D7E0..3D7FF, then 3D7C0..3D7DF; mem_req drops when fifo_count + in_flight = 64.
REQ-034 Consumer pulses vid_req once per 32 cycles after the FIFO is full -> viddata equals the word at each issued address, in order, 2 cycles after each rising edge; underrun stays 0.
REQ-035 Full frame with LINES=4 -> exactly 128 reads accepted; state DONE; last address 3D7E0-96+31 = 3D79F; no further mem_req until next vsync.
REQ-036 Pop before any data arrives -> viddata = 0 and underrun = 1; next vsync rising edge -> underrun = 0.
REQ-037 vsync rising edge with 3 reads in flight and FIFO half full -> FIFO empty next cycle; the 3 late returns are discarded; first new read at BASE issued only after in_flight = 0.
REQ-038 Arbiter withholds mem_ack for 10 cycles with mem_req high -> mem_adr is stable throughout; the address advances by exactly 1 after the ack.
